inv_countdown: RTL and testbench
================================

Name: inv_countdown

Overview:
Parametrised successor to the team's fixed 4-bit inverse code decoder. A load converts an input code to its inverted value (MAXV - code) and latches it as a countdown preset. The block then decrements once per tick until it reaches zero, with pause, busy, done and error reporting. It sits between the keypad/code source and the timer display path of the stopwatch/timer datapath.

Parameters:
WIDTH, 4, bit width of code_i and value_o.
MAXV, 5, inversion constant. Codes 0..MAXV-1 are valid and map to MAXV..1. Legal range 1..2^WIDTH-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
load_i  input  1  single-cycle strobe: decode code_i and preset the counter.
code_i  input  WIDTH  code to invert, sampled only when load_i=1.
tick_i  input  1  count-enable strobe (for example, a 1 Hz pulse), one clk wide.
pause_i  input  1  level signal: freezes counting while high.
value_o  output  WIDTH  current countdown value, registered.
busy_o  output  1  high while a countdown is active (RUN or HOLD), registered.
done_o  output  1  one-cycle pulse when the count reaches 0 by ticking, registered.
err_o  output  1  sticky flag: last load carried an invalid code, registered.

Behaviour:
- Clock and reset:
  - reset is synchronous, active-high. Clock is clk.
  - reset has priority over everything, including mid-count.
  - On reset: value_o=0, busy_o=0, done_o=0, err_o=0, state=IDLE.
- Decode:
  - inv = MAXV - code_i when code_i < MAXV; otherwise inv = 0.
  - Use WIDTH-bit unsigned arithmetic. Compare before subtracting, so there is no wrap-around.
- States:
  - IDLE: value_o holds its last value (0 after a done or an invalid load). Ticks are ignored.
  - RUN: counting.
  - HOLD: paused. value_o is frozen and tick_i is ignored.
- Load (accepted in every state; highest priority after reset):
  - Valid code: value_o <= inv, err_o <= 0.
    - Next state is RUN, or HOLD if pause_i=1 in the same cycle.
  - Invalid code: value_o <= 0, err_o <= 1, next state IDLE, no done_o pulse.
  - Latency: the new value_o is visible in the cycle after the load edge.
  - A tick in the same cycle as a load is discarded.
- RUN:
  - pause_i=1 moves to HOLD next cycle. A tick in that same cycle is ignored, because pause wins.
  - tick_i=1 with pause_i=0 and value_o > 1: value_o <= value_o - 1.
  - tick_i=1 with pause_i=0 and value_o == 1: value_o <= 0, done_o <= 1 for exactly one cycle, next state IDLE.
- HOLD:
  - pause_i=0 returns to RUN next cycle.
  - A tick in the cycle pause_i falls is not counted. Counting resumes on the following tick.
- busy_o = 1 exactly when the registered state is RUN or HOLD. It changes in the same cycle value_o takes a load or done result.
- done_o is 0 in every cycle except the single terminal-tick cycle.
- err_o stays set until the next valid load or reset. It does not affect ticking.
- A re-load while in RUN or HOLD restarts the count immediately, with no done pulse for the aborted count.

Test Plan:
- Reset, then load code 0 -> value_o=5, busy_o=1. Five ticks -> 4,3,2,1,0. done_o pulses once on the fifth tick. busy_o=0 afterwards.
- Load codes 1..4 in turn -> value_o=4,3,2,1. Code 4 then one tick -> value 0 and a done pulse.
- Load code 7 (invalid) -> value_o=0, err_o=1, busy_o=0, no done pulse. Then load code 2 -> value_o=3, err_o=0.
- Load 0, one tick (value 4), pause_i=1, three ticks -> value stays 4, busy_o=1. pause_i=0, one tick -> 3.
- Load 0, two ticks (value 3), then load code 3 with a simultaneous tick -> value_o=2, no decrement, no done pulse.
- Load 0, one tick, reset asserted mid-count -> all outputs 0, state IDLE. A subsequent tick leaves value_o=0.
- Param sweep WIDTH=6, MAXV=40: load 39 -> 1, load 40 -> err_o=1. Load 0 then 40 ticks -> done_o exactly once.

Source files
------------

// File: rtl/inv_countdown.sv
// inv_countdown: loads MAXV - code as a countdown preset, then decrements once per tick to zero.
module inv_countdown #(
  parameter int WIDTH = 4,
  parameter int MAXV  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] code_i,
  input  logic             tick_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] value_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  state_t           state_q;
  logic [WIDTH-1:0] value_q;
  logic             busy_q, done_q, err_q;
  logic             code_ok;
  logic [WIDTH-1:0] inv;
  // compare before subtracting so out-of-range codes never wrap
  assign code_ok = code_i < MAX_W;
  assign inv     = code_ok ? MAX_W - code_i : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        value_q <= inv;
        err_q   <= !code_ok;
        busy_q  <= code_ok;
        state_q <= !code_ok ? IDLE : pause_i ? HOLD : RUN;
      end else if (state_q == RUN) begin
        if (pause_i) begin
          state_q <= HOLD;
        end else if (tick_i) begin
          if (value_q <= ONE) begin
            value_q <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            value_q <= value_q - ONE;
          end
        end
      end else if (state_q == HOLD && !pause_i) begin
        state_q <= RUN;
      end
    end
  end
  assign value_o = value_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_inv_countdown.sv
// tb_inv_countdown: directed checks of inv_countdown at default and WIDTH=6/MAXV=40 parameters.
module tb_inv_countdown;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load, tick, pause;
  logic [3:0] code, value;
  logic       busy, done, err;
  logic       load2, tick2, pause2;
  logic [5:0] code2, value2;
  logic       busy2, done2, err2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  inv_countdown dut (
    .clk(clk), .reset(reset), .load_i(load), .code_i(code), .tick_i(tick), .pause_i(pause),
    .value_o(value), .busy_o(busy), .done_o(done), .err_o(err)
  );

  inv_countdown #(.WIDTH(6), .MAXV(40)) dut6 (
    .clk(clk), .reset(reset), .load_i(load2), .code_i(code2), .tick_i(tick2), .pause_i(pause2),
    .value_o(value2), .busy_o(busy2), .done_o(done2), .err_o(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0; tick = 1'b0; reset = 1'b0; load2 = 1'b0; tick2 = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] c);
    load = 1'b1; code = c;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({value, busy, done, err} !== 7'b0) begin
      n_bad++; $display("FAIL reset: got v=%0d b=%0b d=%0b e=%0b want all 0", value, busy, done, err);
    end
  endtask

  task automatic test_full_count();
    do_load(4'd0);
    n_cmp++;
    if (value !== 4'd5 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL load0: got v=%0d b=%0b d=%0b want v=5 b=1 d=0", value, busy, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step();
      n_cmp++;
      if (value !== 4'(4 - i) || done !== (i == 4) || busy !== (i < 4)) begin
        n_bad++;
        $display("FAIL count tick%0d: got v=%0d d=%0b b=%0b want v=%0d d=%0b b=%0b", i, value, done, busy, 4 - i, i == 4, i < 4);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || value !== 4'd0) begin
      n_bad++; $display("FAIL done_single: got d=%0b v=%0d want d=0 v=0", done, value);
    end
  endtask

  task automatic test_codes();
    for (int c = 1; c <= 4; c++) begin
      do_load(4'(c));
      n_cmp++;
      if (value !== 4'(5 - c) || busy !== 1'b1 || err !== 1'b0) begin
        n_bad++; $display("FAIL code%0d: got v=%0d b=%0b e=%0b want v=%0d b=1 e=0", c, value, busy, err, 5 - c);
      end
    end
    tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL code4_tick: got v=%0d d=%0b b=%0b want v=0 d=1 b=0", value, done, busy);
    end
  endtask

  task automatic test_invalid();
    do_load(4'd0);
    tick = 1'b1;
    step();
    do_load(4'd7);
    n_cmp++;
    if (value !== 4'd0 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL invalid7: got v=%0d e=%0b b=%0b d=%0b want v=0 e=1 b=0 d=0", value, err, busy, done);
    end
    do_load(4'd5);
    tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd0 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL invalid5_sticky: got v=%0d e=%0b b=%0b d=%0b want v=0 e=1 b=0 d=0", value, err, busy, done);
    end
    do_load(4'd2);
    n_cmp++;
    if (value !== 4'd3 || err !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reload2: got v=%0d e=%0b b=%0b want v=3 e=0 b=1", value, err, busy);
    end
  endtask

  task automatic test_pause();
    do_load(4'd0);
    tick = 1'b1;
    step();
    pause = 1'b1; tick = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
    end
    n_cmp++;
    if (value !== 4'd4 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL hold: got v=%0d b=%0b d=%0b want v=4 b=1 d=0", value, busy, done);
    end
    pause = 1'b0; tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd4) begin
      n_bad++; $display("FAIL resume_edge: got v=%0d want v=4", value);
    end
    tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd3 || busy !== 1'b1) begin
      n_bad++; $display("FAIL resume_tick: got v=%0d b=%0b want v=3 b=1", value, busy);
    end
    pause = 1'b1;
    do_load(4'd1);
    tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd4 || busy !== 1'b1) begin
      n_bad++; $display("FAIL load_into_hold: got v=%0d b=%0b want v=4 b=1", value, busy);
    end
    pause = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_load(4'd0);
    tick = 1'b1;
    step();
    tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd3) begin
      n_bad++; $display("FAIL b2b_pre: got v=%0d want v=3", value);
    end
    tick = 1'b1;
    do_load(4'd3);
    n_cmp++;
    if (value !== 4'd2 || done !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_reload: got v=%0d d=%0b b=%0b want v=2 d=0 b=1", value, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_load(4'd0);
    tick = 1'b1;
    step();
    reset = 1'b1; tick = 1'b1;
    step();
    n_cmp++;
    if ({value, busy, done, err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_mid: got v=%0d b=%0b d=%0b e=%0b want all 0", value, busy, done, err);
    end
    tick = 1'b1;
    step();
    n_cmp++;
    if (value !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL idle_tick: got v=%0d b=%0b d=%0b want v=0 b=0 d=0", value, busy, done);
    end
  endtask

  task automatic test_param();
    int pulses = 0;
    load2 = 1'b1; code2 = 6'd39;
    step();
    n_cmp++;
    if (value2 !== 6'd1 || err2 !== 1'b0 || busy2 !== 1'b1) begin
      n_bad++; $display("FAIL w6_load39: got v=%0d e=%0b b=%0b want v=1 e=0 b=1", value2, err2, busy2);
    end
    load2 = 1'b1; code2 = 6'd40;
    step();
    n_cmp++;
    if (value2 !== 6'd0 || err2 !== 1'b1 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL w6_load40: got v=%0d e=%0b b=%0b want v=0 e=1 b=0", value2, err2, busy2);
    end
    load2 = 1'b1; code2 = 6'd0;
    step();
    n_cmp++;
    if (value2 !== 6'd40 || err2 !== 1'b0) begin
      n_bad++; $display("FAIL w6_load0: got v=%0d e=%0b want v=40 e=0", value2, err2);
    end
    for (int i = 0; i < 42; i++) begin
      tick2 = 1'b1;
      step();
      pulses += int'(done2);
      if (i == 38) begin
        n_cmp++;
        if (value2 !== 6'd1 || done2 !== 1'b0) begin
          n_bad++; $display("FAIL w6_tick39: got v=%0d d=%0b want v=1 d=0", value2, done2);
        end
      end
    end
    n_cmp++;
    if (pulses !== 1 || value2 !== 6'd0 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL w6_done: got pulses=%0d v=%0d b=%0b want pulses=1 v=0 b=0", pulses, value2, busy2);
    end
  endtask

  initial begin
    load = 1'b0; tick = 1'b0; pause = 1'b0; code = '0;
    load2 = 1'b0; tick2 = 1'b0; pause2 = 1'b0; code2 = '0;
    test_reset();
    test_full_count();
    test_codes();
    test_invalid();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
